uart_word_tx: RTL

- Downstream consumer of the CPU-side word FIFO.
- Pops D_BITS-wide words through the FIFO read port (rd_en/dout/empty).
- Serialises each word as D_BITS/8 UART frames on a single tx line: 8N1, LSB first, byte 0 (bits [7:0]) first.
- Gives the CPU a fire-and-forget debug/console output path.

---
 rtl/cpu_uart_pkg.sv | 20 ++
 rtl/uart_baud_tick.sv | 27 ++
 rtl/uart_word_tx.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cpu_uart_pkg.sv
// rtl/cpu_uart_pkg.sv - shared state encoding and UART framing constants
package cpu_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } uart_state_e;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] i_byte);
        return ^i_byte;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-cell counter, tick on the last cycle of each cell
module uart_baud_tick #(
    parameter int CLK_DIV = 868
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tick = (r_cnt == CW'(CLK_DIV - 1));

endmodule

// File: rtl/uart_word_tx.sv
// rtl/uart_word_tx.sv - pops FIFO words and sends them as 8N1 UART bytes, LSB byte first
// UART_WORD_TX_PARITY_EN adds an even-parity cell after the data bits.
module uart_word_tx
    import cpu_uart_pkg::*;
#(
    parameter int D_BITS  = 32,
    parameter int CLK_DIV = 868
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [D_BITS-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy
);

    localparam int NBYTES = D_BITS / UART_DATA_BITS;
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    uart_state_e       r_state;
    uart_state_e       w_next;
    logic [D_BITS-1:0] r_word;
    logic [D_BITS-1:0] w_word_n;
    logic [BW-1:0]     r_byte_idx;
    logic [BW-1:0]     w_byte_idx_n;
    logic [2:0]        r_bit_idx;
    logic [2:0]        w_bit_idx_n;
    logic [7:0]        w_byte_n;
    logic              w_tick;
    logic              w_clear;
    logic              w_last_byte;
    logic              w_last_bit;
    logic              w_tx_n;
    logic              w_rd_en_n;
    logic              w_busy_n;
    logic              r_tx;
    logic              r_rd_en;
    logic              r_busy;

    assign w_last_byte = (r_byte_idx == BW'(NBYTES - 1));
    assign w_last_bit  = (r_bit_idx == 3'(UART_DATA_BITS - 1));
    // Restarting the counter on every transition keeps each cell exactly CLK_DIV cycles.
    assign w_clear     = (w_next != r_state);

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_clear (w_clear),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (r_rd_en) w_next = FETCH;
            FETCH:  w_next = START;
            START:  if (w_tick) w_next = DATA;
`ifdef UART_WORD_TX_PARITY_EN
            DATA:   if (w_tick && w_last_bit) w_next = PARITY;
            PARITY: if (w_tick) w_next = STOP;
`else
            DATA:   if (w_tick && w_last_bit) w_next = STOP;
`endif
            STOP:   if (w_tick) w_next = w_last_byte ? IDLE : START;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_word_n     = r_word;
        w_byte_idx_n = r_byte_idx;
        w_bit_idx_n  = r_bit_idx;
        case (r_state)
            FETCH: begin
                w_word_n     = fifo_dout;
                w_byte_idx_n = '0;
            end
            START: if (w_tick) w_bit_idx_n = '0;
            DATA:  if (w_tick && !w_last_bit) w_bit_idx_n = r_bit_idx + 3'd1;
            STOP:  if (w_tick && !w_last_byte) w_byte_idx_n = r_byte_idx + BW'(1);
            default: ;
        endcase
    end

    assign w_byte_n = w_word_n[{w_byte_idx_n, 3'b000} +: UART_DATA_BITS];

    // Outputs are computed from the upcoming state so the registered line lines up with it.
    always_comb begin
        w_tx_n = UART_IDLE_LEVEL;
        case (w_next)
            START:   w_tx_n = 1'b0;
            DATA:    w_tx_n = w_byte_n[w_bit_idx_n];
            PARITY:  w_tx_n = even_parity(w_byte_n);
            default: w_tx_n = UART_IDLE_LEVEL;
        endcase
        w_rd_en_n = (w_next == IDLE) && !fifo_empty;
        w_busy_n  = (w_next != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx       <= UART_IDLE_LEVEL;
            r_rd_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_word     <= '0;
            r_byte_idx <= '0;
            r_bit_idx  <= '0;
        end else begin
            r_tx       <= w_tx_n;
            r_rd_en    <= w_rd_en_n;
            r_busy     <= w_busy_n;
            r_word     <= w_word_n;
            r_byte_idx <= w_byte_idx_n;
            r_bit_idx  <= w_bit_idx_n;
        end
    end

    assign tx         = r_tx;
    assign fifo_rd_en = r_rd_en;
    assign busy       = r_busy;

endmodule
